register_file_clear_bypass: RTL and testbench

Parametrised integer register file for the RV32I core, sitting between decode (read addresses) and writeback (write port). Provides two asynchronous read ports and one synchronous write port, with a hardwired-zero entry 0, same-cycle write-to-read bypass, and a reset-triggered clear sequencer. The sequencer zeroes every entry after reset, so software never sees uninitialised register contents.

---
 rtl/register_file_clear_bypass.sv | 81 ++++++++
 tb/tb_register_file_clear_bypass.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_clear_bypass.sv
// Two-read / one-write integer register file with hardwired-zero entry 0,
// same-cycle write bypass and a post-reset clear sequencer.
module register_file_clear_bypass #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] register_write_select,
    input  logic [DATA_WIDTH-1:0] register_data_write,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] register_data_1,
    output logic [DATA_WIDTH-1:0] register_data_2,
    output logic                  ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_index;
    logic [DATA_WIDTH-1:0]   array [DEPTH];
    logic                    write_accept;

    // A user write lands only once the clear has finished and never on a hardwired x0.
    assign write_accept = ready && (state == RUN) && write_enable &&
                          !(ZERO_REG && (register_write_select == '0));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= CLEAR;
            clear_index <= '0;
            ready       <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    array[clear_index] <= '0;
                    if (clear_index == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clear_index <= clear_index + ADDR_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (write_accept) begin
                        array[register_write_select] <= register_data_write;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] data;
        data = '0;
        if (!ready) begin
            data = '0;
        end else if (ZERO_REG && (addr == '0)) begin
            data = '0;
        end else if (BYPASS && write_accept && (addr == register_write_select)) begin
            data = register_data_write;
        end else begin
            data = array[addr];
        end
        return data;
    endfunction

    assign register_data_1 = read_port(rs1);
    assign register_data_2 = read_port(rs2);

endmodule

// File: tb/tb_register_file_clear_bypass.sv
// Directed bench: default, no-bypass, no-zero-reg and 64x8 instances of the register file.
module tb_register_file_clear_bypass;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned WDW = 64;
    localparam int unsigned WAW = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          we;
    logic [AW-1:0] wsel, rs1, rs2;
    logic [DW-1:0] wdata;
    logic [DW-1:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c;
    logic          rdy_a, rdy_b, rdy_c;

    logic           w_we;
    logic [WAW-1:0] w_sel, w_rs1, w_rs2;
    logic [WDW-1:0] w_wdata, w_d1, w_d2;
    logic           w_rdy;

    int checks = 0;
    int errors = 0;

    register_file_clear_bypass u_dflt (
        .clock(clock), .reset(reset), .write_enable(we), .register_write_select(wsel),
        .register_data_write(wdata), .rs1(rs1), .rs2(rs2),
        .register_data_1(d1_a), .register_data_2(d2_a), .ready(rdy_a));

    register_file_clear_bypass #(.BYPASS(1'b0)) u_nobyp (
        .clock(clock), .reset(reset), .write_enable(we), .register_write_select(wsel),
        .register_data_write(wdata), .rs1(rs1), .rs2(rs2),
        .register_data_1(d1_b), .register_data_2(d2_b), .ready(rdy_b));

    register_file_clear_bypass #(.ZERO_REG(1'b0)) u_nozero (
        .clock(clock), .reset(reset), .write_enable(we), .register_write_select(wsel),
        .register_data_write(wdata), .rs1(rs1), .rs2(rs2),
        .register_data_1(d1_c), .register_data_2(d2_c), .ready(rdy_c));

    register_file_clear_bypass #(.DATA_WIDTH(WDW), .ADDR_WIDTH(WAW)) u_wide (
        .clock(clock), .reset(reset), .write_enable(w_we), .register_write_select(w_sel),
        .register_data_write(w_wdata), .rs1(w_rs1), .rs2(w_rs2),
        .register_data_1(w_d1), .register_data_2(w_d2), .ready(w_rdy));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                        input logic [DW-1:0] ec);
        check({tag, "_dflt_p1"},   64'(d1_a), 64'(ea));
        check({tag, "_nobyp_p1"},  64'(d1_b), 64'(eb));
        check({tag, "_nozero_p1"}, 64'(d1_c), 64'(ec));
    endtask

    task automatic chk2(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                        input logic [DW-1:0] ec);
        check({tag, "_dflt_p2"},   64'(d2_a), 64'(ea));
        check({tag, "_nobyp_p2"},  64'(d2_b), 64'(eb));
        check({tag, "_nozero_p2"}, 64'(d2_c), 64'(ec));
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        check({tag, "_dflt"},   64'(rdy_a), 64'(exp));
        check({tag, "_nobyp"},  64'(rdy_b), 64'(exp));
        check({tag, "_nozero"}, 64'(rdy_c), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; we = 1'b0; wsel = '0; wdata = '0; rs1 = 5'd3; rs2 = 5'd4;
        w_we = 1'b0; w_sel = '0; w_wdata = '0; w_rs1 = 3'd1; w_rs2 = 3'd2;

        // Reset state
        step(); step();
        chk_ready("rst_ready", 1'b0);
        check("rst_ready_wide", 64'(w_rdy), 64'd0);
        chk1("rst_rd", '0, '0, '0);
        chk2("rst_rd", '0, '0, '0);
        check("rst_rd_wide", w_d1, 64'd0);

        // Initial clear: 32 edges for the 32-entry files, 8 for the wide one
        reset = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_ready("clr0_ready", 1'(k == 32));
            check("clr0_ready_wide", 64'(w_rdy), 64'(k >= 8));
        end

        // Wide instance round trip
        w_we = 1'b1; w_sel = 3'd7; w_wdata = 64'h0123_4567_89AB_CDEF;
        step();
        w_we = 1'b0; w_rs1 = 3'd7; w_rs2 = 3'd0;
        #1;
        check("wide_rd7", w_d1, 64'h0123_4567_89AB_CDEF);
        check("wide_rd0", w_d2, 64'd0);

        // Plain write then read
        we = 1'b1; wsel = 5'd5; wdata = 32'hDEAD_BEEF;
        step();
        we = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
        #1;
        chk1("wr_x5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk2("rd_x6", '0, '0, '0);

        // Same-cycle bypass on both ports
        we = 1'b1; wsel = 5'd7; wdata = 32'h1234_5678; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        chk1("byp_pre", 32'h1234_5678, 32'h0, 32'h1234_5678);
        chk2("byp_pre", 32'h1234_5678, 32'h0, 32'h1234_5678);
        step();
        we = 1'b0;
        #1;
        chk1("byp_post", 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

        // Hardwired zero entry
        we = 1'b1; wsel = 5'd0; wdata = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd7;
        #1;
        chk1("x0_pre", 32'h0, 32'h0, 32'hFFFF_FFFF);
        step();
        we = 1'b0;
        #1;
        chk1("x0_post", 32'h0, 32'h0, 32'hFFFF_FFFF);

        // Preload x1..x31, then a reset with a write presented on the reset edge
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wsel = AW'(i); wdata = 32'h1000_0000 + 32'(i);
            step();
        end
        we = 1'b0; rs1 = 5'd31; rs2 = 5'd9;
        #1;
        chk1("preload_x31", 32'h1000_001F, 32'h1000_001F, 32'h1000_001F);
        reset = 1'b0; we = 1'b1; wsel = 5'd9; wdata = 32'hBAD0_0009;
        step();
        we = 1'b0;
        step();
        chk_ready("rst1_ready", 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_ready("clr1_ready", 1'(k == 32));
        end
        for (int i = 0; i < 32; i++) begin
            rs1 = AW'(i); rs2 = AW'(31 - i);
            #1;
            chk1("clr1_rd", '0, '0, '0);
            chk2("clr1_rd", '0, '0, '0);
        end

        // Reset mid-clear; writes held through the whole restarted clear are dropped
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (10) step();
        chk_ready("mid_ready", 1'b0);
        reset = 1'b0; we = 1'b1; wsel = 5'd20; wdata = 32'h5555_5555;
        step();
        reset = 1'b1; wsel = 5'd3; wdata = 32'h3333_3333;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_ready("clr2_ready", 1'(k == 32));
        end
        we = 1'b0; rs1 = 5'd3; rs2 = 5'd20;
        #1;
        chk1("clr2_x3", '0, '0, '0);
        chk2("clr2_x20", '0, '0, '0);

        // First accepted write lands on the edge after ready rises
        we = 1'b1; wsel = 5'd3; wdata = 32'h3333_3333;
        step();
        we = 1'b0;
        #1;
        chk1("first_wr", 32'h3333_3333, 32'h3333_3333, 32'h3333_3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
